// File: rtl/fft_frame_feeder.sv
// ---------------------------------------------------------------------------
// fft_frame_feeder
//
// Gathers sparse audio samples into FFT_SIZE-sample frames using two
// ping-pong banks and streams each finished frame to the FFT core's slave
// data port as one AXI-Stream burst (tlast on the final sample). One bank
// can fill while the other streams.
//
// Ports:
//   clk_in           system clock
//   rst_in           asynchronous active-high reset
//   audio_sample_in  signed audio sample, SAMPLE_W bits
//   audio_valid_in   one-cycle strobe, sample accepted when high
//   m_axis_tdata     {16'h0 imag, sign-extended 16-bit real}
//   m_axis_tvalid    beat valid
//   m_axis_tready    FFT ready
//   m_axis_tlast     high on the last sample of a frame
//   overflow_out     high in the cycle a sample is dropped
//   frame_count_out  frames fully transmitted, wraps modulo 2^16
//
// Handshake: a beat transfers on a rising clk_in edge where m_axis_tvalid
// and m_axis_tready are both high. Once tvalid rises it stays high, with
// tdata/tlast stable, until the tlast beat transfers.
// ---------------------------------------------------------------------------
module fft_frame_feeder #(
    parameter int FFT_SIZE = 1024,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [SAMPLE_W-1:0] audio_sample_in,
    input  logic                audio_valid_in,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                overflow_out,
    output logic [15:0]         frame_count_out
);

    localparam int IDX_W = $clog2(FFT_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_SIZE - 1);

    typedef enum logic [1:0] {
        B_FREE      = 2'd0,
        B_FILLING   = 2'd1,
        B_FULL      = 2'd2,
        B_STREAMING = 2'd3
    } bank_st_e;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_FETCH  = 2'd1,
        R_STREAM = 2'd2
    } rd_state_e;

    // Both banks live in one array; the bank number is the address MSB.
    logic [SAMPLE_W-1:0] mem [2*FFT_SIZE];
    logic [SAMPLE_W-1:0] rd_data_q;

    // Bank status
    bank_st_e bank_st_q [2];
    bank_st_e bank_st_d [2];

    // Writer
    logic             wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0] wr_idx_q,  wr_idx_d;
    logic             drop_q,    drop_d;
    logic             wr_en;
    logic             frame_end;
    logic             other_bank;
    logic             other_free;

    // Reader
    rd_state_e        rd_state_q, rd_state_d;
    logic             rd_bank_q,  rd_bank_d;
    logic [IDX_W-1:0] rd_idx_q,   rd_idx_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             rd_claim;
    logic             rd_sel;
    logic             any_full;
    logic             beat_fire;
    logic             release_en;
    logic [15:0]      real_ext;

    // ---------------------------------------------------------------------
    // Shared helper terms
    // ---------------------------------------------------------------------
    always_comb begin
        beat_fire  = (rd_state_q == R_STREAM) && m_axis_tready;
        release_en = beat_fire && (rd_idx_q == LAST_IDX);
        other_bank = ~wr_bank_q;
        // A release of the other bank in this same cycle counts as free, so a
        // frame finishing exactly as the reader lets go never overflows.
        other_free = (bank_st_q[other_bank] == B_FREE) ||
                     (release_en && (rd_bank_q == other_bank));
        wr_en      = audio_valid_in && !drop_q;
        frame_end  = wr_en && (wr_idx_q == LAST_IDX);
        any_full   = (bank_st_q[0] == B_FULL) || (bank_st_q[1] == B_FULL);
        rd_sel     = (bank_st_q[0] == B_FULL) ? 1'b0 : 1'b1;
    end

    // ---------------------------------------------------------------------
    // Writer next state
    // ---------------------------------------------------------------------
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        drop_d    = drop_q;
        if (drop_q) begin
            // Resume only at index 0 of a freed bank: partial frames never exist.
            if (other_free) begin
                wr_bank_d = other_bank;
                wr_idx_d  = '0;
                drop_d    = 1'b0;
            end
        end else if (wr_en) begin
            wr_idx_d = wr_idx_q + 1'b1;
            if (frame_end) begin
                wr_idx_d = '0;
                if (other_free) begin
                    wr_bank_d = other_bank;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Reader FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        frame_cnt_d = frame_cnt_q;
        rd_claim    = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (any_full) begin
                    rd_claim   = 1'b1;
                    rd_bank_d  = rd_sel;
                    rd_idx_d   = '0;
                    rd_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rd_state_d = R_STREAM;
            end
            R_STREAM: begin
                if (release_en) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    rd_state_d  = R_IDLE;
                end else if (beat_fire) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Bank status next state (writer and reader never touch the same bank
    // in the same cycle: the writer owns FREE/FILLING, the reader FULL/STREAMING)
    // ---------------------------------------------------------------------
    always_comb begin
        bank_st_d = bank_st_q;
        if (wr_en) begin
            bank_st_d[wr_bank_q] = frame_end ? B_FULL : B_FILLING;
        end
        if (rd_claim) begin
            bank_st_d[rd_sel] = B_STREAMING;
        end
        if (release_en) begin
            bank_st_d[rd_bank_q] = B_FREE;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bank_st_q[0] <= B_FREE;
            bank_st_q[1] <= B_FREE;
            wr_bank_q    <= 1'b0;
            wr_idx_q     <= '0;
            drop_q       <= 1'b0;
            rd_state_q   <= R_IDLE;
            rd_bank_q    <= 1'b0;
            rd_idx_q     <= '0;
            frame_cnt_q  <= 16'd0;
        end else begin
            bank_st_q    <= bank_st_d;
            wr_bank_q    <= wr_bank_d;
            wr_idx_q     <= wr_idx_d;
            drop_q       <= drop_d;
            rd_state_q   <= rd_state_d;
            rd_bank_q    <= rd_bank_d;
            rd_idx_q     <= rd_idx_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Sample RAM. The read address is the reader's next index, so the
    // registered read data always matches the beat presented next cycle;
    // this gives back-to-back beats without a skid buffer and holds the
    // data steady while stalled.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[{wr_bank_q, wr_idx_q}] <= audio_sample_in;
        end
        rd_data_q <= mem[{rd_bank_d, rd_idx_d}];
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        real_ext        = 16'($signed(rd_data_q));
        m_axis_tvalid   = (rd_state_q == R_STREAM);
        m_axis_tlast    = m_axis_tvalid && (rd_idx_q == LAST_IDX);
        m_axis_tdata    = m_axis_tvalid ? {16'h0000, real_ext} : 32'h0000_0000;
        overflow_out    = drop_q && audio_valid_in;
        frame_count_out = frame_cnt_q;
    end

endmodule
